// File: rtl/multi_channel_timer.sv
// multi_channel_timer
//   Memory-mapped machine timer. One free-running CNT_W-bit mtime counter,
//   advanced by a programmable prescaler, plus NUM_CH compare channels. Each
//   channel is one-shot or periodic (auto-reload by PERIOD). Each channel has
//   a sticky pending flag that drives irq[k]. timer_interrupt is the OR of
//   all pending flags.
//
//   Word map:
//     0        CTRL      [0]=run, [8+:PRESC_W]=presc
//     1 / 2    MTIME_LO / MTIME_HI (HI holds bits [CNT_W-1:32], zero-padded)
//     4+4k     CMP_LO    channel k
//     5+4k     CMP_HI    channel k
//     6+4k     CHCTRL    [0]=en [1]=periodic [2]=pending (write 1 to clear)
//     7+4k     PERIOD    32-bit reload increment, zero-extended
//   Unmapped words and channels k>=NUM_CH read as 0 and ignore writes.
//
// Ports
//   CLK              system clock
//   RESETN           asynchronous active-low reset
//   wr_en            single-cycle register write strobe
//   rd_en            register read strobe; rdata is updated on the next edge
//   addr[5:0]        word address
//   wdata[31:0]      write data
//   rdata[31:0]      registered read data, held until the next rd_en
//   irq[NUM_CH-1:0]  per-channel pending flags
//   timer_interrupt  OR of irq

module multi_channel_timer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 8
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [5:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq,
  output logic              timer_interrupt
);

  localparam int HI_W = CNT_W - 32;

  logic               run_q, run_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   mtime_q, mtime_d;
  logic [CNT_W-1:0]   cmp_q [NUM_CH];
  logic [CNT_W-1:0]   cmp_d [NUM_CH];
  logic [31:0]        period_q [NUM_CH];
  logic [31:0]        period_d [NUM_CH];
  logic [NUM_CH-1:0]  en_q, en_d;
  logic [NUM_CH-1:0]  periodic_q, periodic_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               tick;
  logic [NUM_CH-1:0]  hit;
  logic [NUM_CH-1:0]  chSel;
  logic               globalSel;
  logic [1:0]         wordOff;

  // Address decode: addr[5:2]==0 selects the global block, addr[5:2]==k+1
  // selects channel k, and addr[1:0] picks the word within the block.
  always_comb begin
    globalSel = (addr[5:2] == 4'd0);
    wordOff   = addr[1:0];
    chSel     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      chSel[k] = (addr[5:2] == 4'(k + 1));
    end
  end

  // Prescaler and mtime. When run is low, pcnt is held at zero, so a restart
  // always waits a full presc+1 cycles. A software write to either mtime half
  // replaces that half and suppresses the increment for this cycle.
  always_comb begin
    run_d   = run_q;
    presc_d = presc_q;
    tick    = run_q && (pcnt_q == presc_q);

    if (!run_q || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end

    mtime_d = tick ? (mtime_q + CNT_W'(1)) : mtime_q;

    if (wr_en && globalSel) begin
      case (wordOff)
        2'd0: begin
          run_d   = wdata[0];
          presc_d = wdata[8 +: PRESC_W];
        end
        2'd1: mtime_d = {mtime_q[CNT_W-1:32], wdata};
        2'd2: mtime_d = {wdata[HI_W-1:0], mtime_q[31:0]};
        default: ;
      endcase
    end
  end

  // Compare channels. A hit sets pending. A periodic channel with a nonzero
  // PERIOD reloads cmp and stays enabled; otherwise the channel disables
  // itself. Software writes to CMP or CHCTRL override the hardware update
  // made in the same cycle. For pending, a hardware set beats a W1C clear,
  // so a hit that coincides with a clear is not lost.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cmp_d[k]      = cmp_q[k];
      period_d[k]   = period_q[k];
      en_d[k]       = en_q[k];
      periodic_d[k] = periodic_q[k];
      hit[k]        = en_q[k] && (mtime_q >= cmp_q[k]);

      if (hit[k]) begin
        if (periodic_q[k] && (period_q[k] != 32'd0)) begin
          cmp_d[k] = cmp_q[k] + CNT_W'(period_q[k]);
        end else begin
          en_d[k] = 1'b0;
        end
      end

      if (wr_en && chSel[k]) begin
        case (wordOff)
          2'd0: cmp_d[k] = {cmp_q[k][CNT_W-1:32], wdata};
          2'd1: cmp_d[k] = {wdata[HI_W-1:0], cmp_q[k][31:0]};
          2'd2: begin
            en_d[k]       = wdata[0];
            periodic_d[k] = wdata[1];
          end
          default: period_d[k] = wdata;
        endcase
      end

      pending_d[k] = hit[k] |
                     (pending_q[k] & ~(wr_en && chSel[k] && (wordOff == 2'd2) && wdata[2]));
    end
  end

  // Read mux. The result is captured only when rd_en is high, so rdata holds
  // its value between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      if (globalSel) begin
        case (wordOff)
          2'd0: begin
            rdata_d[0]            = run_q;
            rdata_d[8 +: PRESC_W] = presc_q;
          end
          2'd1: rdata_d = mtime_q[31:0];
          2'd2: rdata_d = 32'(mtime_q[CNT_W-1:32]);
          default: ;
        endcase
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (chSel[k]) begin
          case (wordOff)
            2'd0: rdata_d = cmp_q[k][31:0];
            2'd1: rdata_d = 32'(cmp_q[k][CNT_W-1:32]);
            2'd2: rdata_d = {29'd0, pending_q[k], periodic_q[k], en_q[k]};
            default: rdata_d = period_q[k];
          endcase
        end
      end
    end
  end

  // State registers. All state returns to zero on reset.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      run_q      <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      mtime_q    <= '0;
      en_q       <= '0;
      periodic_q <= '0;
      pending_q  <= '0;
      rdata_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cmp_q[k]    <= '0;
        period_q[k] <= '0;
      end
    end else begin
      run_q      <= run_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      mtime_q    <= mtime_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      rdata_q    <= rdata_d;
      for (int k = 0; k < NUM_CH; k++) begin
        cmp_q[k]    <= cmp_d[k];
        period_q[k] <= period_d[k];
      end
    end
  end

  assign rdata           = rdata_q;
  assign irq             = pending_q;
  assign timer_interrupt = |pending_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// tb_multi_channel_timer
//   Self-checking bench for multi_channel_timer with default parameters
//   (NUM_CH=4, CNT_W=64, PRESC_W=8). A table of write/readback vectors
//   covers the register map. Hand-written sequences cover compare timing,
//   periodic reload, prescaling, wrap-around, set/clear races and reset.

module tb_multi_channel_timer;

  logic        CLK;
  logic        RESETN;
  logic        wr_en;
  logic        rd_en;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  irq;
  logic        timer_interrupt;

  int compared;
  int mismatched;

  multi_channel_timer #(
    .NUM_CH (4),
    .CNT_W  (64),
    .PRESC_W(8)
  ) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .irq            (irq),
    .timer_interrupt(timer_interrupt)
  );

  // 100 MHz-style free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Safety net so the run always ends even if the DUT wedges a wait loop
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs [12];

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // One-cycle register write; back-to-back calls land on consecutive edges
  task automatic busWrite(input logic [5:0] a, input logic [31:0] d);
    @(negedge CLK);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge CLK);
    #1;
    wr_en = 1'b0;
  endtask

  // One-cycle register read; returns the registered rdata after the edge
  task automatic busRead(input logic [5:0] a, output logic [31:0] d);
    @(negedge CLK);
    rd_en = 1'b1;
    addr  = a;
    @(posedge CLK);
    #1;
    rd_en = 1'b0;
    d     = rdata;
  endtask

  // Apply one table vector: write, read back, compare
  task automatic applyStimulus(input int idx);
    logic [31:0] rd;
    string nm;
    busWrite(vecs[idx].addr, vecs[idx].wdata);
    busRead(vecs[idx].addr, rd);
    nm = $sformatf("vec%0d_addr%0d", idx, vecs[idx].addr);
    checkOutput(nm, rd, vecs[idx].expRd);
  endtask

  initial begin
    logic [31:0] rd;
    int cnt;
    int e;

    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{6'd0,  32'hFFFF_FF00, 32'h0000_FF00};
    vecs[1]  = '{6'd1,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2]  = '{6'd2,  32'h1234_5678, 32'h1234_5678};
    vecs[3]  = '{6'd3,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4]  = '{6'd4,  32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[5]  = '{6'd5,  32'h0000_0001, 32'h0000_0001};
    vecs[6]  = '{6'd6,  32'hFFFF_FFFE, 32'h0000_0002};
    vecs[7]  = '{6'd7,  32'h0000_0004, 32'h0000_0004};
    vecs[8]  = '{6'd14, 32'h0000_0002, 32'h0000_0002};
    vecs[9]  = '{6'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[10] = '{6'd20, 32'h0000_0055, 32'h0000_0000};
    vecs[11] = '{6'd63, 32'h0000_0055, 32'h0000_0000};

    // Reset state
    RESETN = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    addr   = '0;
    wdata  = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_irq", {28'd0, irq}, 32'h0);
    checkOutput("reset_ti", {31'd0, timer_interrupt}, 32'h0);
    @(negedge CLK);
    RESETN = 1'b1;
    busRead(6'd0, rd);
    checkOutput("reset_ctrl", rd, 32'h0);
    busRead(6'd1, rd);
    checkOutput("reset_mtime_lo", rd, 32'h0);

    // Register map write/readback table
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i);
    end

    // One-shot channel 0 at mtime 10, presc 0
    busWrite(6'd0, 32'h0);
    busWrite(6'd2, 32'h0);
    busWrite(6'd1, 32'h0);
    busWrite(6'd5, 32'h0);
    busWrite(6'd4, 32'd10);
    busWrite(6'd6, 32'h5);
    busWrite(6'd0, 32'h1);
    cnt = 0;
    while (!irq[0] && cnt < 40) begin
      @(posedge CLK);
      #1;
      cnt++;
    end
    checkOutput("oneshot_latency", cnt, 32'd11);
    checkOutput("oneshot_ti", {31'd0, timer_interrupt}, 32'h1);
    busWrite(6'd0, 32'h0);
    busRead(6'd6, rd);
    checkOutput("oneshot_chctrl", rd, 32'h4);
    busWrite(6'd6, 32'h4);
    #1;
    checkOutput("oneshot_w1c_irq", {28'd0, irq}, 32'h0);

    // Periodic channel 1: CMP=5, PERIOD=4, hits at 5, 9, 13
    busWrite(6'd2, 32'h0);
    busWrite(6'd1, 32'h0);
    busWrite(6'd9, 32'h0);
    busWrite(6'd8, 32'd5);
    busWrite(6'd11, 32'd4);
    busWrite(6'd10, 32'h7);
    for (int it = 0; it < 3; it++) begin
      e = 5 + 4 * it;
      busWrite(6'd1, 32'(e - 1));
      checkOutput($sformatf("periodic_idle_%0d", e), {31'd0, irq[1]}, 32'h0);
      busWrite(6'd0, 32'h1);
      busWrite(6'd0, 32'h0);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("periodic_hit_%0d", e), {31'd0, irq[1]}, 32'h1);
      busRead(6'd8, rd);
      checkOutput($sformatf("periodic_cmp_%0d", e), rd, 32'(e + 4));
      busWrite(6'd10, 32'h7);
    end

    // SW CMP write on the reload cycle overrides the reload
    busWrite(6'd1, 32'd17);
    busWrite(6'd8, 32'd100);
    busRead(6'd8, rd);
    checkOutput("cmp_sw_wins", rd, 32'd100);
    checkOutput("cmp_sw_wins_irq", {31'd0, irq[1]}, 32'h1);
    busWrite(6'd10, 32'h4);

    // W1C in the same cycle as a new hit: pending stays set
    busWrite(6'd1, 32'h0);
    busWrite(6'd4, 32'd50);
    busWrite(6'd6, 32'h5);
    busWrite(6'd1, 32'd50);
    busWrite(6'd6, 32'h4);
    checkOutput("w1c_race_irq", {31'd0, irq[0]}, 32'h1);
    busRead(6'd6, rd);
    checkOutput("w1c_race_chctrl", rd, 32'h4);
    busWrite(6'd6, 32'h4);
    checkOutput("w1c_clear_irq", {31'd0, irq[0]}, 32'h0);

    // Prescaler 3: one tick per 4 cycles; stopping clears the phase
    busWrite(6'd1, 32'h0);
    busWrite(6'd0, 32'h301);
    repeat (9) @(posedge CLK);
    busWrite(6'd0, 32'h300);
    busRead(6'd1, rd);
    checkOutput("presc_count", rd, 32'd2);
    repeat (5) @(posedge CLK);
    busRead(6'd1, rd);
    checkOutput("presc_frozen", rd, 32'd2);
    busWrite(6'd0, 32'h301);
    repeat (2) @(posedge CLK);
    busWrite(6'd0, 32'h300);
    busRead(6'd1, rd);
    checkOutput("presc_phase_clear", rd, 32'd2);

    // Wrap: periodic cmp at 2^64-1 reloads past zero and hits again at 1
    busWrite(6'd0, 32'h0);
    busWrite(6'd2, 32'hFFFF_FFFF);
    busWrite(6'd1, 32'hFFFF_FFFE);
    busWrite(6'd13, 32'hFFFF_FFFF);
    busWrite(6'd12, 32'hFFFF_FFFF);
    busWrite(6'd15, 32'd2);
    busWrite(6'd14, 32'h7);
    busWrite(6'd0, 32'h1);
    repeat (3) @(posedge CLK);
    busWrite(6'd0, 32'h0);
    busRead(6'd12, rd);
    checkOutput("wrap_cmp_lo", rd, 32'd3);
    busRead(6'd13, rd);
    checkOutput("wrap_cmp_hi", rd, 32'd0);
    busRead(6'd1, rd);
    checkOutput("wrap_mtime_lo", rd, 32'd2);
    busRead(6'd2, rd);
    checkOutput("wrap_mtime_hi", rd, 32'd0);
    checkOutput("wrap_irq", {31'd0, irq[2]}, 32'h1);
    busWrite(6'd14, 32'h4);

    // Asynchronous reset mid-count with an interrupt pending
    busWrite(6'd2, 32'h0);
    busWrite(6'd1, 32'h0);
    busWrite(6'd4, 32'd5);
    busWrite(6'd6, 32'h5);
    busWrite(6'd0, 32'h1);
    repeat (10) @(posedge CLK);
    #1;
    checkOutput("pre_reset_irq", {31'd0, irq[0]}, 32'h1);
    busRead(6'd0, rd);
    checkOutput("pre_reset_ctrl", rd, 32'h1);
    #2;
    RESETN = 1'b0;
    #1;
    checkOutput("async_reset_irq", {28'd0, irq}, 32'h0);
    checkOutput("async_reset_ti", {31'd0, timer_interrupt}, 32'h0);
    checkOutput("async_reset_rdata", rdata, 32'h0);
    @(negedge CLK);
    RESETN = 1'b1;
    busRead(6'd0, rd);
    checkOutput("post_reset_ctrl", rd, 32'h0);
    busRead(6'd1, rd);
    checkOutput("post_reset_mtime", rd, 32'h0);
    busRead(6'd4, rd);
    checkOutput("post_reset_cmp0", rd, 32'h0);

    // rdata holds between reads; unmapped reads return 0
    busWrite(6'd7, 32'h1234);
    busRead(6'd7, rd);
    checkOutput("period_readback", rd, 32'h1234);
    busWrite(6'd7, 32'h5678);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rdata_hold", rdata, 32'h1234);
    busRead(6'd3, rd);
    checkOutput("unmapped_3", rd, 32'h0);
    busRead(6'd36, rd);
    checkOutput("unmapped_ch8", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
